gcbp_line_packer: RTL

Packs the 1-bit-per-pixel GCBP stream for one 128x64 sub-image window into 128-bit BRAM words, one word per window line. Sits directly upstream of the GCBP BRAM address decoder. It supplies that decoder's line count and new-frame pulse, and the write data/enable that accompany the decoder's write address into the BRAM array.

---
 rtl/gcbp_line_packer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/gcbp_line_packer.sv
// Packs one 128x64 window of a 1-bpp GCBP pixel stream into 128-bit words, one per window line.
// Write 1 cycle after the last-column pixel, new_frame 1 cycle after line 63's write; no backpressure.
module gcbp_line_packer #(
    parameter int C_FRAME_W = 640,
    parameter int C_FRAME_H = 480,
    parameter int C_WIN_X0  = 256,
    parameter int C_WIN_Y0  = 208
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_pix_valid,
    input  logic         i_pix_bit,
    input  logic         i_sof,
    output logic         o_wr_en,
    output logic [127:0] o_wr_data,
    output logic [9:0]   o_line_count,
    output logic         o_new_frame,
    output logic         o_frame_abort,
    output logic         o_busy
);

    localparam int XW = $clog2(C_FRAME_W);
    localparam int YW = $clog2(C_FRAME_H);

    localparam logic [XW-1:0] X_LAST   = XW'(C_FRAME_W - 1);
    localparam logic [XW-1:0] WX_FIRST = XW'(C_WIN_X0);
    localparam logic [XW-1:0] WX_LAST  = XW'(C_WIN_X0 + 127);
    localparam logic [YW-1:0] Y_LAST   = YW'(C_FRAME_H - 1);
    localparam logic [YW-1:0] WY_FIRST = YW'(C_WIN_Y0);
    localparam logic [YW-1:0] WY_LAST  = YW'(C_WIN_Y0 + 63);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ACTIVE,
        S_DONE,
        S_POST
    } state_t;

    // A window starting on row 0 is entered directly on the start-of-frame pixel.
    localparam state_t RESTART_ST = (C_WIN_Y0 == 0) ? S_ACTIVE : S_PRE;

    state_t         state_q;
    logic [XW-1:0]  x_q, x_d, px;
    logic [YW-1:0]  y_q, y_d, py;
    logic           ovf_q, ovf_d;
    logic [127:0]   shift_q;
    logic [127:0]   wr_data_q;
    logic [9:0]     line_q;
    logic           wr_en_q;
    logic           new_frame_q;
    logic           abort_q;

    logic           start;
    logic           pix_ok;
    logic           in_win;
    logic           pack;
    logic           wr_now;
    logic           last_line;
    logic [6:0]     col;

    always_comb begin
        start  = i_pix_valid && i_sof;
        // Once the frame's last pixel has passed, stray pixels are ignored until the next sof.
        pix_ok = i_pix_valid && (i_sof || !ovf_q);
        px     = i_sof ? '0 : x_q;
        py     = i_sof ? '0 : y_q;

        x_d   = x_q;
        y_d   = y_q;
        ovf_d = ovf_q;
        if (start) begin
            x_d   = XW'(1);
            y_d   = '0;
            ovf_d = 1'b0;
        end else if (pix_ok) begin
            if (x_q == X_LAST) begin
                if (y_q == Y_LAST) begin
                    ovf_d = 1'b1;
                end else begin
                    x_d = '0;
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
        end

        in_win    = (px >= WX_FIRST) && (px <= WX_LAST) && (py >= WY_FIRST) && (py <= WY_LAST);
        col       = 7'(px - WX_FIRST);
        pack      = pix_ok && in_win && ((state_q != S_IDLE) || start);
        wr_now    = pack && (px == WX_LAST);
        last_line = (py == WY_LAST);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            ovf_q       <= 1'b0;
            shift_q     <= '0;
            wr_data_q   <= '0;
            line_q      <= '0;
            wr_en_q     <= 1'b0;
            new_frame_q <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            ovf_q       <= ovf_d;
            wr_en_q     <= 1'b0;
            new_frame_q <= 1'b0;
            abort_q     <= 1'b0;

            // Column 0 lands in bit 127; the last column bypasses shift_q into the word.
            if (pack) begin
                shift_q[~col] <= i_pix_bit;
            end
            if (wr_now) begin
                wr_en_q   <= 1'b1;
                wr_data_q <= {shift_q[127:1], i_pix_bit};
                line_q    <= 10'(py - WY_FIRST);
            end

            case (state_q)
                S_IDLE, S_POST: begin
                    if (start) state_q <= RESTART_ST;
                end
                S_PRE: begin
                    if (start) begin
                        state_q <= RESTART_ST;
                    end else if (pix_ok && (py == WY_FIRST)) begin
                        state_q <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (start) begin
                        abort_q <= 1'b1;
                        state_q <= RESTART_ST;
                    end else if (wr_now && last_line) begin
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    // A sof here (window at the bottom-right corner) still lets the pulse out.
                    new_frame_q <= 1'b1;
                    state_q     <= start ? RESTART_ST : S_POST;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign o_wr_en       = wr_en_q;
    assign o_wr_data     = wr_data_q;
    assign o_line_count  = line_q;
    assign o_new_frame   = new_frame_q;
    assign o_frame_abort = abort_q;
    assign o_busy        = (state_q == S_ACTIVE);

endmodule
